// File: rtl/phy_pkg.sv
// Shared PHY definitions for the serial receiver, the transmitter and the 8-to-32 packer:
// symbol width, the idle/alignment comma and the receiver state encoding.
package phy_pkg;

    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] COMMA = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ALIGNED = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

    // Saturating 4-bit increment, used for the comma run counter.
    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
        return (value >= limit) ? limit : value + 4'd1;
    endfunction

endpackage

// File: rtl/serial_paralelo_rx_if.sv
// Serial-in / parallel-out bundle of the byte-alignment receiver.
// The receiver takes the slave side; the upstream serialiser or a bench takes the master side.
interface serial_paralelo_rx_if;
    import phy_pkg::*;

    logic              data_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active
    );

endinterface

// File: rtl/serial_paralelo_rx_comma_detect.sv
// Combinational match of a symbol-wide window against the idle comma.
// Shared with the transmitter-side checker.
module comma_detect
    import phy_pkg::*;
(
    input  logic [DATA_W-1:0] win,
    output logic              is_comma
);

    assign is_comma = (win == COMMA);

endmodule

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: finds byte alignment on the 0xBC comma, locks after LOCK_COUNT
// aligned commas and emits non-comma bytes. Optional SERIAL_REALIGN_EN re-aligns on misaligned commas.
module serial_paralelo_rx
    import phy_pkg::*;
#(
    parameter int LOCK_COUNT = 4
)
(
    input  logic               clk_32f,
    input  logic               reset,
    serial_paralelo_rx_if.slave rx
);

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_COUNT);
    localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

    rx_state_t         state_reg, state_next;
    // Only the previous DATA_W-1 bits are needed: the window appends the bit being sampled.
    logic [DATA_W-2:0] shift_reg;
    logic [2:0]        bit_cnt_reg, bit_cnt_next;
    logic [3:0]        com_cnt_reg, com_cnt_next;
    logic [3:0]        com_inc;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              valid_reg, valid_next;
    logic [DATA_W-1:0] win;
    logic              is_comma;
    logic              boundary;

    assign win      = {shift_reg, rx.data_in};
    assign boundary = (bit_cnt_reg == LAST_BIT);
    assign com_inc  = sat_inc(com_cnt_reg, LOCK_LIM);

    comma_detect u_comma_detect (
        .win      (win),
        .is_comma (is_comma)
    );

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg + 3'd1;
        com_cnt_next = com_cnt_reg;
        data_next    = data_reg;
        valid_next   = valid_reg;

        unique case (state_reg)
            SEARCH: begin
                valid_next = 1'b0;
                if (is_comma) begin
                    bit_cnt_next = 3'd0;
                    com_cnt_next = 4'd1;
                    state_next   = (LOCK_LIM == 4'd1) ? LOCKED : ALIGNED;
                end
            end

            ALIGNED: begin
                valid_next = 1'b0;
                if (boundary) begin
                    if (is_comma) begin
                        com_cnt_next = com_inc;
                        if (com_inc == LOCK_LIM) begin
                            state_next = LOCKED;
                        end
                    end else begin
                        com_cnt_next = 4'd0;
                        state_next   = SEARCH;
                    end
                end
            end

            LOCKED: begin
                if (boundary) begin
                    if (is_comma) begin
                        valid_next = 1'b0;
                    end else begin
                        data_next  = win;
                        valid_next = 1'b1;
                    end
                end
`ifdef SERIAL_REALIGN_EN
                else if (is_comma) begin
                    // A comma off the byte grid means we slipped; restart counting from it.
                    bit_cnt_next = 3'd0;
                    com_cnt_next = 4'd1;
                    valid_next   = 1'b0;
                    state_next   = ALIGNED;
                end
`endif
            end

            default: begin
                state_next = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_reg   <= SEARCH;
            shift_reg   <= '0;
            bit_cnt_reg <= 3'd0;
            com_cnt_reg <= 4'd0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= win[DATA_W-2:0];
            bit_cnt_reg <= bit_cnt_next;
            com_cnt_reg <= com_cnt_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
        end
    end

    assign rx.data_out  = data_reg;
    assign rx.valid_out = valid_reg;
    assign rx.active    = (state_reg == LOCKED);

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx (LOCK_COUNT = 4); realignment expectations follow SERIAL_REALIGN_EN.
module tb_serial_paralelo_rx;
    import phy_pkg::*;

    logic clk_32f;
    logic reset;
    int   checks;
    int   failures;

    serial_paralelo_rx_if rx_if ();

    serial_paralelo_rx #(.LOCK_COUNT(4)) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .rx      (rx_if.slave)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%02h expected=0x%02h", tag, got, exp);
        end
    endtask

    // Present one bit at the falling edge; return 1 time unit after the sampling edge.
    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        rx_if.data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        $display("byte 0x%02h data_out=0x%02h valid_out=%0b active=%0b",
                 v, rx_if.data_out, rx_if.valid_out, rx_if.active);
    endtask

    task automatic check_outs(input string tag, input logic [7:0] d, input logic v, input logic a);
        check_val({tag, "_data"},   rx_if.data_out, d);
        check_val({tag, "_valid"},  {7'd0, rx_if.valid_out}, {7'd0, v});
        check_val({tag, "_active"}, {7'd0, rx_if.active}, {7'd0, a});
    endtask

    // Reset one full cycle, released between edges so the next bit is the first sampled.
    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk_32f);
        #2;
        rx_if.data_in = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] pay;
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        rx_if.data_in = 1'b0;

        // Reset held with random serial data
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_32f);
            rx_if.data_in = 1'($urandom_range(0, 1));
            @(posedge clk_32f);
            #1;
            check_outs("reset_hold", 8'h00, 1'b0, 1'b0);
        end
        #1;
        reset = 1'b1;

        // Lock from four aligned commas, then data
        send_byte(COMMA);
        send_byte(COMMA);
        send_byte(COMMA);
        check_outs("lock_c3", 8'h00, 1'b0, 1'b0);
        send_byte(COMMA);
        check_outs("lock_c4_edge32", 8'h00, 1'b0, 1'b1);
        send_byte(8'hA5);
        check_outs("data_a5_edge40", 8'hA5, 1'b1, 1'b1);
        pay = 8'h3C;
        for (int i = 7; i >= 4; i--) send_bit(pay[i]);
        check_outs("hold_a5_mid", 8'hA5, 1'b1, 1'b1);
        for (int i = 3; i >= 0; i--) send_bit(pay[i]);
        check_outs("data_3c_edge48", 8'h3C, 1'b1, 1'b1);

        // Idle comma while locked
        send_byte(8'h77);
        check_outs("idle_77", 8'h77, 1'b1, 1'b1);
        send_byte(COMMA);
        check_outs("idle_comma", 8'h77, 1'b0, 1'b1);
        send_byte(8'h88);
        check_outs("idle_88", 8'h88, 1'b1, 1'b1);

        // Comma shifted 3 bits off the byte grid: 0x17,0x80 -> 000_10111 100_00000
        send_byte(8'h17);
        check_outs("skew_17", 8'h17, 1'b1, 1'b1);
        send_byte(8'h80);
`ifdef SERIAL_REALIGN_EN
        check_outs("skew_realign", 8'h17, 1'b0, 1'b0);
`else
        check_outs("skew_ignored", 8'h80, 1'b1, 1'b1);
`endif

        // Asynchronous reset mid-byte, then relock
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_outs("reset_async", 8'h00, 1'b0, 1'b0);
        pulse_reset();
        for (int k = 0; k < 4; k++) send_byte(COMMA);
        check_outs("relock", 8'h00, 1'b0, 1'b1);
        send_byte(8'h99);
        check_outs("relock_99", 8'h99, 1'b1, 1'b1);

        // Misaligned start: three junk bits before the preamble
        pulse_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int k = 0; k < 3; k++) send_byte(COMMA);
        check_outs("skewstart_c3", 8'h00, 1'b0, 1'b0);
        send_byte(COMMA);
        check_outs("skewstart_lock", 8'h00, 1'b0, 1'b1);
        send_byte(8'h5A);
        check_outs("skewstart_5a", 8'h5A, 1'b1, 1'b1);

        // Broken preamble: 0x11 interrupts the comma run and must never appear
        pulse_reset();
        for (int k = 0; k < 3; k++) send_byte(COMMA);
        send_byte(8'h11);
        check_outs("broken_11", 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) send_byte(COMMA);
        check_outs("broken_c3", 8'h00, 1'b0, 1'b0);
        send_byte(COMMA);
        check_outs("broken_lock", 8'h00, 1'b0, 1'b1);
        send_byte(8'h22);
        check_outs("broken_22", 8'h22, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_rx.md
# serial_paralelo_rx

Serial-to-parallel receiver that recovers byte alignment from a 1-bit serial stream and delivers 8-bit words plus a valid flag. It sits directly upstream of the 8-to-32 byte packer: its `data_out`/`valid_out` drive that packer's `data_in`/`valid_in`. Alignment uses the idle comma byte 0xBC, which the transmitter sends whenever it has no valid data. Lock is declared after a configurable number of consecutive aligned commas.

## Interface
- `DATA_W`, 8: parallel word width, equal to bits per symbol.
- `COMMA`, 8'hBC: idle/alignment symbol.
- `LOCK_COUNT`, 4: consecutive aligned commas required to declare lock; range 1..15.

Ports:
- `clk_32f`  in  1: serial bit clock, 8× the byte clock `clk_4f` of the downstream packer. Single clock; all state is on its rising edge.
- `reset`  in  1: asynchronous, active-low. 0 clears all state; 1 means run.
- `data_in`  in  1: serial bit, MSB of each symbol first.
- `data_out`  out  DATA_W: last received non-comma byte.
- `valid_out`  out  1: `data_out` holds a fresh data byte for the current byte period.
- `active`  out  1: receiver is locked (state LOCKED).

## Operation
- Shift register: `shift <= {shift[6:0], data_in}` on every edge. The comparison window is `win = {shift[6:0], data_in}`, the value that is being registered.
- Bit counter `bit_cnt` is 3 bits wide and wraps 7→0. A boundary is the edge where `bit_cnt == 7`. At a boundary, `win` is a complete symbol.
- Comma counter `com_cnt` is 4 bits wide and saturates at LOCK_COUNT.
- SEARCH, the reset state:
  - Every edge, if `win == COMMA`: `bit_cnt <= 0`, `com_cnt <= 1`, go to ALIGNED. If LOCK_COUNT == 1, go straight to LOCKED instead.
  - Otherwise `bit_cnt` free-runs.
- ALIGNED, evaluated only at boundaries:
  - `win == COMMA`: increment `com_cnt`. When the incremented value equals LOCK_COUNT, go to LOCKED.
  - `win != COMMA`: `com_cnt <= 0`, go to SEARCH.
- LOCKED, evaluated only at boundaries:
  - `win != COMMA`: `data_out <= win`, `valid_out <= 1`.
  - `win == COMMA`: `valid_out <= 0`, `data_out` holds its value.
- Between boundaries, `data_out` and `valid_out` hold, so each stays stable for 8 `clk_32f` cycles, one `clk_4f` period.
- `valid_out` is 0 whenever the state is not LOCKED. Bytes received in SEARCH or ALIGNED are never output.
- Once LOCKED, the receiver stays locked until reset (see Configuration for the exception).
- Commas straddling a boundary inside payload are a known hazard. They are only acted on with `REALIGN_EN`.

## Timing
- Reset values: `data_out = 0`, `valid_out = 0`, `active = 0`, `shift = 0`, `bit_cnt = 0`, `com_cnt = 0`, state SEARCH.
- Reset is asynchronous and takes effect immediately, including mid-byte or while LOCKED. Lock must be reacquired from SEARCH afterwards.
- Output latency: `data_out`/`valid_out` update on the same edge that samples the symbol's last bit (LSB). They are visible one cycle after the LSB is presented.
- `active` rises on the edge that samples the LSB of the LOCK_COUNT-th aligned comma.
- Minimum time to lock from an aligned comma start: 8·LOCK_COUNT cycles.
- The first data byte after lock appears 8 cycles after `active` rises.

## Configuration
- `SERIAL_REALIGN_EN` defined:
  - In LOCKED, a `win == COMMA` match while `bit_cnt != 7` is a misaligned comma.
  - On that match: `bit_cnt <= 0`, `com_cnt <= 1`, state ALIGNED, `active <= 0`, `valid_out <= 0`.
- `SERIAL_REALIGN_EN` undefined: misaligned matches are ignored and lock persists until reset.

## Structure
- Shared package `phy_pkg` holds:
  - the `COMMA` constant (8'hBC);
  - the state enum `rx_state_t` (SEARCH, ALIGNED, LOCKED), with 2-bit encoding;
  - the `DATA_W` constant, also used by the 8-to-32 packer and the transmitter.
- Sub-module `comma_detect`: combinational compare of `win` against `COMMA`. It outputs `is_comma`. It is reused by the transmitter-side checker.
- FSM, counters and output registers live in the top module.

## Test plan
- Reset: hold `reset = 0` for 3 cycles with random `data_in` → `data_out = 0`, `valid_out = 0`, `active = 0` throughout.
- Lock plus data: 4×0xBC then 0xA5, 0x3C → `active = 1` at the 32nd edge; `data_out = 0xA5` with `valid_out = 1` at edge 40; `data_out = 0x3C` at edge 48.
- Misaligned start: 3 junk bits 101, then 4×0xBC then 0x5A → alignment found at the first comma's LSB; `data_out = 0x5A`, `valid_out = 1`.
- Broken preamble: 3×0xBC, 0x11, 4×0xBC, 0x22 → return to SEARCH after 0x11 and 0x11 never output; lock after the second preamble; `data_out = 0x22`.
- Idle while locked: locked, send 0x77, 0xBC, 0x88 → `valid_out` goes 1, 0, 1; `data_out` holds 0x77 during the comma period.
- Reset mid-op: assert `reset` mid-byte while LOCKED → all outputs 0 immediately; 4 commas then 0x99 → relock, `data_out = 0x99`.
- With `SERIAL_REALIGN_EN`, while LOCKED inject one 0xBC shifted 3 bits off the boundary → `active = 0`, `valid_out = 0`, state ALIGNED.
